alu_reg_file: RTL and testbench

//  Parametrised operand-register/ALU datapath for the bus-based CPU. NREGS general registers load from
//  the shared bus; a registered ALU works on two selected registers; the result register and any register

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_reg_file.sv | 144 ++++++++++++++
 tb/tb_alu_reg_file.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the operand-register/ALU datapath: opcodes, flag bit
// positions and multiply FSM state encodings.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_CMP   = 3'd5,
        ALU_MUL   = 3'd6,
        ALU_PASSA = 3'd7
    } alu_op_t;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: ADD/SUB/CMP/logic/PASSA with {N,V,C,Z} and
// unsigned greater-than. MUL is handled by the sequential datapath in the top.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             gt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Carry on subtraction means "no borrow", i.e. a >= b unsigned.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB, ALU_CMP: begin
                res   = diff[WIDTH-1:0];
                carry = ~diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_PASSA: res = a;
            default:   res = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (res == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
        flags[FLG_N] = res[WIDTH-1];
    end

    assign gt = (a > b);

endmodule

// File: rtl/alu_reg_file.sv
// Operand register file, bus interface, registered ALU results/flags and an
// iterative shift-add multiplier for the bus-based CPU.
module alu_reg_file
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int SELW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic             ld,
    input  logic [SELW-1:0]  ld_sel,
    input  logic             er,
    input  logic [SELW-1:0]  er_sel,
    input  logic [SELW-1:0]  a_sel,
    input  logic [SELW-1:0]  b_sel,
    input  logic [2:0]       op,
    input  logic             go,
    input  logic             ev,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags,
    output logic             gt,
    output logic             bus_err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         rst_sync;
    logic               rst_n;
    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   result;
    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               mul_c;
    alu_op_t            op_e;
    logic [WIDTH-1:0]   a_val;
    logic [WIDTH-1:0]   b_val;
    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;
    logic               core_gt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign op_e  = alu_op_t'(op);
    assign a_val = regs[a_sel];
    assign b_val = regs[b_sel];
    assign mul_c = |acc[2*WIDTH-1:WIDTH];
    assign busy  = (state == ST_RUN);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (a_val),
        .b     (b_val),
        .op    (op_e),
        .res   (core_res),
        .flags (core_flags),
        .gt    (core_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (ld) begin
            regs[ld_sel] <= bus_in;
        end
    end

    // Result register has priority when both drivers are requested.
    always_comb begin
        bus_out = '0;
        if (ev)      bus_out = result;
        else if (er) bus_out = regs[er_sel];
    end
    assign bus_oe = er | ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_err <= 1'b0;
        else        bus_err <= er & ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            result <= '0;
            flags  <= '0;
            gt     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        if (op_e == ALU_MUL) begin
                            state  <= ST_RUN;
                            cnt    <= CW'(WIDTH);
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_val};
                            mplier <= b_val;
                        end else begin
                            if (op_e != ALU_CMP) result <= core_res;
                            if (op_e == ALU_SUB || op_e == ALU_CMP) gt <= core_gt;
                            flags <= core_flags;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    result       <= acc[WIDTH-1:0];
                    flags[FLG_Z] <= (acc[WIDTH-1:0] == '0);
                    flags[FLG_C] <= mul_c;
                    flags[FLG_V] <= mul_c;
                    flags[FLG_N] <= acc[WIDTH-1];
                    done         <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed self-checking bench for alu_reg_file (WIDTH=8, NREGS=4).
module tb_alu_reg_file;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic [7:0] bus_in = '0;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       ld = 1'b0;
    logic [1:0] ld_sel = '0;
    logic       er = 1'b0;
    logic [1:0] er_sel = '0;
    logic [1:0] a_sel = '0;
    logic [1:0] b_sel = '0;
    logic [2:0] op = '0;
    logic       go = 1'b0;
    logic       ev = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] flags;
    logic       gt;
    logic       bus_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    alu_reg_file #(.WIDTH(8), .NREGS(4)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .ld      (ld),
        .ld_sel  (ld_sel),
        .er      (er),
        .er_sel  (er_sel),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .op      (op),
        .go      (go),
        .ev      (ev),
        .busy    (busy),
        .done    (done),
        .flags   (flags),
        .gt      (gt),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [7:0] v);
        ld = 1'b1; ld_sel = r; bus_in = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b);
        op = o; a_sel = a; b_sel = b; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] expected);
        ev = 1'b1;
        #1;
        checkOutput(tag, {24'b0, bus_out}, {24'b0, expected});
        ev = 1'b0;
        #1;
    endtask

    initial begin
        int busy_cnt;
        int done_at;

        // Asynchronous reset with idle inputs
        #2 clr_n = 1'b0;
        #1;
        checkOutput("rst_busy",    {31'b0, busy},    32'd0);
        checkOutput("rst_done",    {31'b0, done},    32'd0);
        checkOutput("rst_flags",   {28'b0, flags},   32'd0);
        checkOutput("rst_gt",      {31'b0, gt},      32'd0);
        checkOutput("rst_bus_err", {31'b0, bus_err}, 32'd0);
        checkOutput("rst_bus_oe",  {31'b0, bus_oe},  32'd0);
        checkOutput("rst_bus_out", {24'b0, bus_out}, 32'd0);
        tick(); tick();
        check_result("rst_result", 8'h00);
        clr_n = 1'b1;
        tick(); tick(); tick();

        // 5 + 3
        load_reg(2'd0, 8'h05);
        load_reg(2'd1, 8'h03);
        er = 1'b1; er_sel = 2'd0;
        #1;
        checkOutput("er_r0_bus",    {24'b0, bus_out}, 32'h05);
        checkOutput("er_r0_bus_oe", {31'b0, bus_oe},  32'd1);
        er = 1'b0;
        applyStimulus(ALU_ADD, 2'd0, 2'd1);
        checkOutput("add_done",  {31'b0, done},  32'd1);
        checkOutput("add_flags", {28'b0, flags}, 32'h0);
        check_result("add_result", 8'h08);
        tick();
        checkOutput("add_done_pulse", {31'b0, done}, 32'd0);

        // Carry-out wraparound and signed overflow
        load_reg(2'd2, 8'hFF);
        load_reg(2'd3, 8'h01);
        applyStimulus(ALU_ADD, 2'd2, 2'd3);
        checkOutput("add_wrap_flags", {28'b0, flags}, 32'h3);
        check_result("add_wrap_result", 8'h00);
        load_reg(2'd2, 8'h7F);
        applyStimulus(ALU_ADD, 2'd2, 2'd3);
        checkOutput("add_ovf_flags", {28'b0, flags}, 32'hC);
        check_result("add_ovf_result", 8'h80);

        // CMP leaves result alone
        load_reg(2'd0, 8'h03);
        load_reg(2'd1, 8'h05);
        applyStimulus(ALU_CMP, 2'd0, 2'd1);
        checkOutput("cmp_lt_done",  {31'b0, done},  32'd1);
        checkOutput("cmp_lt_flags", {28'b0, flags}, 32'h8);
        checkOutput("cmp_lt_gt",    {31'b0, gt},    32'd0);
        check_result("cmp_lt_result_kept", 8'h80);
        load_reg(2'd0, 8'h09);
        load_reg(2'd1, 8'h02);
        applyStimulus(ALU_CMP, 2'd0, 2'd1);
        checkOutput("cmp_gt_flags", {28'b0, flags}, 32'h2);
        checkOutput("cmp_gt_gt",    {31'b0, gt},    32'd1);
        check_result("cmp_gt_result_kept", 8'h80);

        // Logic op must not touch gt
        applyStimulus(ALU_XOR, 2'd0, 2'd0);
        checkOutput("xor_flags", {28'b0, flags}, 32'h1);
        checkOutput("xor_gt_kept", {31'b0, gt}, 32'd1);
        check_result("xor_result", 8'h00);

        // 2 - 9 borrows
        applyStimulus(ALU_SUB, 2'd1, 2'd0);
        checkOutput("sub_flags", {28'b0, flags}, 32'h8);
        checkOutput("sub_gt",    {31'b0, gt},    32'd0);
        check_result("sub_result", 8'hF9);

        // 0x12 * 0x0F, with an operand rewrite and an ignored go during RUN
        load_reg(2'd0, 8'h12);
        load_reg(2'd1, 8'h0F);
        applyStimulus(ALU_MUL, 2'd0, 2'd1);
        busy_cnt = 0;
        done_at  = -1;
        for (int n = 0; n < 40 && done_at < 0; n++) begin
            if (busy) busy_cnt++;
            if (done) done_at = n;
            if (n == 2) begin ld = 1'b1; ld_sel = 2'd0; bus_in = 8'h01; end
            if (n == 3) begin ld = 1'b0; op = ALU_ADD; a_sel = 2'd0; b_sel = 2'd1; go = 1'b1; end
            if (n == 4) go = 1'b0;
            if (n == 5) check_result("mul_result_held", 8'hF9);
            if (done_at < 0) tick();
        end
        checkOutput("mul_busy_cycles", busy_cnt, 32'd8);
        checkOutput("mul_done_latency", done_at, 32'd9);
        checkOutput("mul_flags", {28'b0, flags}, 32'h6);
        check_result("mul_result", 8'h0E);
        tick();
        checkOutput("mul_done_pulse", {31'b0, done}, 32'd0);
        checkOutput("mul_busy_clear", {31'b0, busy}, 32'd0);

        // Bus contention: result wins, error pulses next cycle
        er = 1'b1; er_sel = 2'd1; ev = 1'b1;
        #1;
        checkOutput("erev_bus_out", {24'b0, bus_out}, 32'h0E);
        checkOutput("erev_bus_oe",  {31'b0, bus_oe},  32'd1);
        tick();
        checkOutput("bus_err_set", {31'b0, bus_err}, 32'd1);
        er = 1'b0; ev = 1'b0;
        tick();
        checkOutput("bus_err_clear", {31'b0, bus_err}, 32'd0);

        // Same-edge load and go: ALU sees the old r0
        ld = 1'b1; ld_sel = 2'd0; bus_in = 8'h20;
        applyStimulus(ALU_PASSA, 2'd0, 2'd1);
        ld = 1'b0;
        check_result("passa_old_r0", 8'h01);
        checkOutput("passa_flags", {28'b0, flags}, 32'h0);
        er = 1'b1; er_sel = 2'd0;
        #1;
        checkOutput("r0_after_load", {24'b0, bus_out}, 32'h20);
        er = 1'b0;

        applyStimulus(ALU_CMP, 2'd0, 2'd1);
        checkOutput("cmp2_flags", {28'b0, flags}, 32'h2);
        checkOutput("cmp2_gt",    {31'b0, gt},    32'd1);

        // Reset in the middle of a multiply
        applyStimulus(ALU_MUL, 2'd1, 2'd1);
        tick(); tick();
        checkOutput("mid_mul_busy", {31'b0, busy}, 32'd1);
        clr_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  {31'b0, busy},  32'd0);
        checkOutput("mid_rst_flags", {28'b0, flags}, 32'h0);
        checkOutput("mid_rst_gt",    {31'b0, gt},    32'd0);
        check_result("mid_rst_result", 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("mid_rst_no_done", {31'b0, done}, 32'd0);
        end
        clr_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checkOutput("post_rst_no_done", {31'b0, done}, 32'd0);
        end
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
